// File: rtl/fabric_cfg_pkg.sv
// Shared types, default sizing and checksum helper for the fabric configuration loader.
package fabric_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LD_LUT,
        LD_SB,
        LD_FF,
        LD_CSUM,
        DONE,
        ERROR
    } state_t;

    localparam int unsigned DEF_NUM_LUT = 8;
    localparam int unsigned DEF_LUT_K   = 5;
    localparam int unsigned DEF_NUM_SB  = 7;
    localparam int unsigned DEF_SB_W    = 32;
    localparam int unsigned DEF_WORD_W  = 32;

    localparam int unsigned LUT_BITS    = 2 ** DEF_LUT_K;
    localparam int unsigned LUT_SLICE   = LUT_BITS + 1;
    localparam int unsigned TOTAL_WORDS = DEF_NUM_LUT + DEF_NUM_SB + 2;

    // Widest stream word the checksum helper handles; narrower words are zero-extended.
    localparam int unsigned CSUM_MAX_W  = 64;

    function automatic logic [CSUM_MAX_W-1:0] csum_fold(
        input logic [CSUM_MAX_W-1:0] acc,
        input logic [CSUM_MAX_W-1:0] word
    );
        return acc ^ word;
    endfunction

    function automatic int unsigned imax(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cfg_shadow_bank.sv
// Shadow register array with masked per-entry writes and an atomic copy to the live register.
module cfg_shadow_bank
    import fabric_cfg_pkg::*;
#(
    parameter int unsigned N = 8,
    parameter int unsigned W = 33
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           clear,
    input  logic           commit,
    input  logic [N-1:0]   wr_en,
    input  logic [W-1:0]   wr_mask,
    input  logic [N*W-1:0] wr_data,
    output logic [N*W-1:0] live
);

    logic [N*W-1:0] shadow;
    logic [N*W-1:0] shadow_n;
    logic [N*W-1:0] bit_mask;

    // Expand the per-entry enable and per-bit mask, then merge new data into the shadow.
    always_comb begin
        bit_mask = '0;
        for (int unsigned i = 0; i < N; i++) begin
            bit_mask[i*W +: W] = wr_en[i] ? wr_mask : '0;
        end
        if (clear) begin
            shadow_n = '0;
        end else begin
            shadow_n = (shadow & ~bit_mask) | (wr_data & bit_mask);
        end
    end

    // Shadow and live storage; live only moves on commit so no partial state is visible.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shadow <= '0;
            live   <= '0;
        end else begin
            shadow <= shadow_n;
            if (commit) begin
                live <= shadow;
            end
        end
    end

endmodule

// File: rtl/fabric_config_loader.sv
// Streaming configuration loader: assembles LUT/switch-box shadows and commits on a good checksum.
module fabric_config_loader
    import fabric_cfg_pkg::*;
#(
    parameter int unsigned NUM_LUT = DEF_NUM_LUT,
    parameter int unsigned LUT_K   = DEF_LUT_K,
    parameter int unsigned NUM_SB  = DEF_NUM_SB,
    parameter int unsigned SB_W    = DEF_SB_W,
    parameter int unsigned WORD_W  = DEF_WORD_W
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic                               cfg_start,
    input  logic                               cfg_abort,
    input  logic                               cfg_valid,
    input  logic [WORD_W-1:0]                  cfg_data,
    output logic                               cfg_ready,
    output logic [NUM_LUT*(2**LUT_K+1)-1:0]    lut_cfg,
    output logic [NUM_SB*SB_W-1:0]             sb_cfg,
    output logic                               cfg_busy,
    output logic                               cfg_done,
    output logic                               cfg_error
);

    localparam int unsigned L_BITS  = 2 ** LUT_K;
    localparam int unsigned L_SLICE = L_BITS + 1;
    localparam int unsigned CNT_W   = $clog2(imax(NUM_LUT, NUM_SB) + 1);

    localparam logic [L_SLICE-1:0] TT_MASK = {1'b0, {L_BITS{1'b1}}};
    localparam logic [L_SLICE-1:0] FF_MASK = {1'b1, {L_BITS{1'b0}}};

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [WORD_W-1:0]   acc, acc_n;
    logic                ready_n, busy_n, done_n, error_n;
    logic                accept;
    logic                last_lut, last_sb;
    logic [CSUM_MAX_W-1:0] fold;

    logic [NUM_LUT-1:0]         lut_wr_en;
    logic [L_SLICE-1:0]         lut_mask;
    logic [NUM_LUT*L_SLICE-1:0] lut_data;
    logic [NUM_SB-1:0]          sb_wr_en;
    logic [NUM_SB*SB_W-1:0]     sb_data;
    logic                       shadow_clear;
    logic                       commit;

    assign accept   = cfg_valid && cfg_ready && !cfg_abort;
    assign last_lut = (cnt == CNT_W'(NUM_LUT - 1));
    assign last_sb  = (cnt == CNT_W'(NUM_SB - 1));
    assign fold     = csum_fold(CSUM_MAX_W'(acc), CSUM_MAX_W'(cfg_data));

    // Place the incoming word into every slice; the write enables pick which entries take it.
    always_comb begin
        lut_data = '0;
        for (int unsigned i = 0; i < NUM_LUT; i++) begin
            lut_data[i*L_SLICE +: L_SLICE] = {cfg_data[WORD_W-1-i], cfg_data[L_BITS-1:0]};
        end
        sb_data = '0;
        for (int unsigned j = 0; j < NUM_SB; j++) begin
            sb_data[j*SB_W +: SB_W] = cfg_data[SB_W-1:0];
        end
    end

    // Next-state, counter, checksum and shadow write control.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        acc_n        = acc;
        busy_n       = cfg_busy;
        done_n       = cfg_done;
        error_n      = cfg_error;
        lut_wr_en    = '0;
        lut_mask     = '0;
        sb_wr_en     = '0;
        shadow_clear = 1'b0;
        commit       = 1'b0;

        case (state)
            IDLE, DONE, ERROR: begin
                if (cfg_start && cfg_abort) begin
                    state_n = IDLE;
                    done_n  = 1'b0;
                    error_n = 1'b0;
                end else if (cfg_start) begin
                    state_n      = LD_LUT;
                    cnt_n        = '0;
                    acc_n        = '0;
                    busy_n       = 1'b1;
                    done_n       = 1'b0;
                    error_n      = 1'b0;
                    shadow_clear = 1'b1;
                end
            end
            LD_LUT, LD_SB, LD_FF, LD_CSUM: begin
                if (cfg_abort) begin
                    state_n      = IDLE;
                    cnt_n        = '0;
                    acc_n        = '0;
                    busy_n       = 1'b0;
                    done_n       = 1'b0;
                    error_n      = 1'b0;
                    shadow_clear = 1'b1;
                end else if (accept) begin
                    case (state)
                        LD_LUT: begin
                            lut_wr_en = NUM_LUT'(1) << cnt;
                            lut_mask  = TT_MASK;
                            acc_n     = fold[WORD_W-1:0];
                            if (last_lut) begin
                                state_n = LD_SB;
                                cnt_n   = '0;
                            end else begin
                                cnt_n = cnt + 1'b1;
                            end
                        end
                        LD_SB: begin
                            sb_wr_en = NUM_SB'(1) << cnt;
                            acc_n    = fold[WORD_W-1:0];
                            if (last_sb) begin
                                state_n = LD_FF;
                                cnt_n   = '0;
                            end else begin
                                cnt_n = cnt + 1'b1;
                            end
                        end
                        LD_FF: begin
                            lut_wr_en = '1;
                            lut_mask  = FF_MASK;
                            acc_n     = fold[WORD_W-1:0];
                            state_n   = LD_CSUM;
                            cnt_n     = '0;
                        end
                        default: begin
                            busy_n = 1'b0;
                            if (cfg_data == acc) begin
                                commit  = 1'b1;
                                state_n = DONE;
                                done_n  = 1'b1;
                            end else begin
                                state_n = ERROR;
                                error_n = 1'b1;
                            end
                        end
                    endcase
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        ready_n = (state_n == LD_LUT) || (state_n == LD_SB) ||
                  (state_n == LD_FF)  || (state_n == LD_CSUM);
    end

    // State and status registers; cfg_ready is registered from the next state alone.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            cfg_ready <= 1'b0;
            cfg_busy  <= 1'b0;
            cfg_done  <= 1'b0;
            cfg_error <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            acc       <= acc_n;
            cfg_ready <= ready_n;
            cfg_busy  <= busy_n;
            cfg_done  <= done_n;
            cfg_error <= error_n;
        end
    end

    cfg_shadow_bank #(
        .N (NUM_LUT),
        .W (L_SLICE)
    ) u_lut_bank (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (shadow_clear),
        .commit  (commit),
        .wr_en   (lut_wr_en),
        .wr_mask (lut_mask),
        .wr_data (lut_data),
        .live    (lut_cfg)
    );

    cfg_shadow_bank #(
        .N (NUM_SB),
        .W (SB_W)
    ) u_sb_bank (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (shadow_clear),
        .commit  (commit),
        .wr_en   (sb_wr_en),
        .wr_mask ('1),
        .wr_data (sb_data),
        .live    (sb_cfg)
    );

endmodule

// File: doc/fabric_config_loader.md
Name: fabric_config_loader

Overview:
Streaming configuration controller for the FPGA fabric. It accepts a word stream over a valid/ready interface and assembles the LUT truth tables, LUT flop-select bits and switch-box configuration words in shadow registers. After the closing checksum word verifies, it commits all of them atomically to the live configuration buses that drive the LUT and switch-box instances. It replaces backdoor hierarchical loading, is parametrised in LUT count, LUT input count and switch-box count, and adds integrity checking and abort.

Parameters:
NUM_LUT, 8, number of LUTs configured (1..WORD_W)
LUT_K, 5, LUT inputs; truth table is 2**LUT_K bits; 2**LUT_K <= WORD_W
NUM_SB, 7, number of switch boxes
SB_W, 32, switch-box configure width (<= WORD_W)
WORD_W, 32, stream word width

Ports:
clock  in  1  fabric clock, rising edge
reset_n  in  1  asynchronous active-low reset
cfg_start  in  1  one-cycle pulse: begin a load; ignored unless state is IDLE, DONE or ERROR
cfg_abort  in  1  discard the load in progress and return to IDLE
cfg_valid  in  1  cfg_data valid
cfg_data  in  WORD_W  stream word
cfg_ready  out  1  loader accepts a word this cycle
lut_cfg  out  NUM_LUT*(2**LUT_K+1)  live LUT configs; LUT i occupies slice i, bit 2**LUT_K = flop select
sb_cfg  out  NUM_SB*SB_W  live switch-box configs; SB j occupies slice j
cfg_busy  out  1  load in progress
cfg_done  out  1  last load committed; held until next cfg_start
cfg_error  out  1  last load failed checksum; held until next cfg_start

Behaviour:
- Reset (async assert, sync deassert handled upstream): state IDLE. lut_cfg, sb_cfg, shadows, checksum accumulator and word counter all 0. cfg_ready, cfg_busy, cfg_done and cfg_error are 0.
- Transfer: a word is accepted on a rising edge with cfg_valid && cfg_ready. cfg_ready is 1 only in the LD_LUT, LD_SB, LD_FF and LD_CSUM states; it is a registered function of state only and does not depend on cfg_valid. Gaps in cfg_valid stall without penalty.
- Stream order:
  - NUM_LUT truth-table words; the low 2**LUT_K bits are used, the rest ignored.
  - NUM_SB switch-box words; the low SB_W bits are used.
  - One flop-select word: bit (WORD_W-1-i) goes to LUT i.
  - One checksum word.
  - Total words = NUM_LUT+NUM_SB+2 (17 at defaults).
- FSM:
  - IDLE/DONE/ERROR --cfg_start--> LD_LUT. On this edge: clear the accumulator and counter, clear cfg_done and cfg_error, set cfg_busy.
  - LD_LUT --NUM_LUT accepted--> LD_SB.
  - LD_SB --NUM_SB accepted--> LD_FF.
  - LD_FF --1 accepted--> LD_CSUM.
  - LD_CSUM --1 accepted--> DONE if the word equals the accumulator, else ERROR.
- Checksum: the accumulator is the XOR of every full WORD_W data word accepted before the checksum word.
- Commit: on the edge that accepts a matching checksum word, all lut_cfg and sb_cfg slices update together from the shadows, cfg_done goes to 1 and cfg_busy to 0. Latency is zero cycles after acceptance; outputs are visible after that edge.
- Mismatch: cfg_error goes to 1, cfg_busy to 0, and lut_cfg/sb_cfg are unchanged.
- Live outputs never change except at commit or reset. No partial configuration is ever visible.
- cfg_abort in any LD_* state: next state IDLE, cfg_busy 0, shadows discarded, live config unchanged, cfg_done/cfg_error 0. If cfg_abort and an accepted word coincide, abort wins and the word is dropped.
- cfg_abort in IDLE/DONE/ERROR: no effect.
- cfg_start during an LD_* state: ignored. cfg_start together with cfg_abort: abort wins.
- Reset mid-load: everything returns to reset values, including the live config.
- Word counter width: $clog2(max(NUM_LUT,NUM_SB)+1); it is cleared at each phase change.

Decomposition:
- Package fabric_cfg_pkg holds:
  - state enum (IDLE, LD_LUT, LD_SB, LD_FF, LD_CSUM, DONE, ERROR);
  - localparams LUT_BITS=2**LUT_K, LUT_SLICE=LUT_BITS+1, TOTAL_WORDS;
  - checksum-function helper.
- One natural sub-module: cfg_shadow_bank, a parametrised shadow-register array with a per-word write enable and a global commit that copies to the live register. It is instantiated twice, once for LUT and once for SB. Flop-select bits live in the LUT bank at the top bit of each slice.

Test Plan:
1. Reset: assert reset_n=0 mid-run -> lut_cfg=0, sb_cfg=0, cfg_ready=0, cfg_done=0, cfg_error=0 immediately (asynchronous).
2. Nominal load: pulse cfg_start, then send 8 LUT words 0x00000001<<i, 7 SB words 0xA5A50000+j, FF word 0xF0000000, correct XOR checksum.
   - Required: cfg_done=1 on the accepting edge.
   - Required: LUT0..3 flop bit=1, LUT4..7=0; SB6=0xA5A50006.
3. Bad checksum: same stream with checksum XOR 0x1 -> cfg_error=1, cfg_done=0, lut_cfg/sb_cfg still hold scenario-2 values.
4. Backpressure gaps: cfg_valid toggles 1,0,0,1 per word -> same result as scenario 2. cfg_ready stays 1 throughout LD_*; no word is lost or duplicated.
5. Abort: cfg_abort after 10 accepted words -> state IDLE, cfg_busy=0, live config unchanged. A following full load with new data commits correctly.
6. cfg_start pulsed at word 5 of a load -> ignored, the load completes with 17 words. cfg_start+cfg_abort in the same cycle -> IDLE.
